// File: rtl/sobel_edge_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sobel_edge_stage: RGB->grey conversion, 3x3 window and Sobel edge magnitude
// in front of the CCD write FIFO. Fixed 4-clock latency, one result per pixel.
// Revision: 1.0
// ---------------------------------------------------------------------------
module sobel_edge_stage #(
    parameter int IMG_WIDTH  = 800,
    parameter int IMG_HEIGHT = 480
) (
    input  logic        CCD_FIFO_WRCLK,
    input  logic        RESET_N,
    input  logic [29:0] iDATA,
    input  logic        iDVAL,
    input  logic        iFRAME_START,
    input  logic [1:0]  iMODE,
    input  logic [9:0]  iTHRESH,
    input  logic        iFIFO_FULL,
    output logic [29:0] oDATA,
    output logic        oDVAL,
    output logic        oOVERFLOW,
    output logic [1:0]  oMODE
);

    localparam int            CW       = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 2;
    localparam int            RW       = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 2;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [9:0]    PIX_MAX  = 10'd1023;

    logic [9:0] lb1_mem [IMG_WIDTH];
    logic [9:0] lb2_mem [IMG_WIDTH];

    logic [CW-1:0] col_q, col_d, col_cur;
    logic [RW-1:0] row_q, row_d, row_cur;
    logic [1:0]    mode_q, mode_d;
    logic [9:0]    win_q [3][3];
    logic [9:0]    win_d [3][3];

    logic          s1_valid_q, s1_valid_d;
    logic [29:0]   s1_data_q, s1_data_d;
    logic [9:0]    s1_grey_q, s1_grey_d;
    logic [1:0]    s1_mode_q, s1_mode_d;
    logic          s1_border_q, s1_border_d;

    logic          s2_valid_q, s2_valid_d;
    logic [29:0]   s2_data_q, s2_data_d;
    logic [9:0]    s2_grey_q, s2_grey_d;
    logic [1:0]    s2_mode_q, s2_mode_d;
    logic          s2_border_q, s2_border_d;
    logic signed [12:0] s2_gx_q, s2_gx_d;
    logic signed [12:0] s2_gy_q, s2_gy_d;

    logic          s3_valid_q, s3_valid_d;
    logic [29:0]   s3_data_q, s3_data_d;
    logic [9:0]    s3_grey_q, s3_grey_d;
    logic [1:0]    s3_mode_q, s3_mode_d;
    logic [9:0]    s3_mag_q, s3_mag_d;

    logic          out_valid_q, out_valid_d;
    logic [29:0]   out_data_q, out_data_d;
    logic          ovf_q, ovf_d;

    logic [11:0]   rgb_sum;
    logic [9:0]    grey;
    logic [9:0]    lb1_rd, lb2_rd;
    logic [12:0]   gx_pos, gx_neg, gy_pos, gy_neg;
    logic [12:0]   abs_x, abs_y;
    logic [13:0]   mag_full;
    logic [9:0]    result;

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        mode_d      = mode_q;
        win_d       = win_q;
        ovf_d       = ovf_q;

        // A frame-start pixel resynchronises position and mode for itself.
        col_cur = iFRAME_START ? '0 : col_q;
        row_cur = iFRAME_START ? '0 : row_q;
        if (iDVAL && iFRAME_START) begin
            mode_d = iMODE;
        end

        rgb_sum = {2'b00, iDATA[29:20]} + {2'b00, iDATA[19:10]} + {2'b00, iDATA[9:0]};
        grey    = 10'(rgb_sum / 12'd3);
        lb1_rd  = lb1_mem[col_cur];
        lb2_rd  = lb2_mem[col_cur];

        if (iDVAL) begin
            col_d = (col_cur == COL_LAST) ? '0 : col_cur + 1'b1;
            if (col_cur == COL_LAST) begin
                row_d = (row_cur == ROW_LAST) ? '0 : row_cur + 1'b1;
            end else begin
                row_d = row_cur;
            end
            for (int i = 0; i < 3; i++) begin
                win_d[i][0] = win_q[i][1];
                win_d[i][1] = win_q[i][2];
            end
            win_d[0][2] = lb2_rd;
            win_d[1][2] = lb1_rd;
            win_d[2][2] = grey;
        end

        s1_valid_d  = iDVAL;
        s1_data_d   = iDATA;
        s1_grey_d   = grey;
        s1_mode_d   = mode_d;
        // Centre sits at (col-1,row-1): first two columns/rows put it on a border.
        s1_border_d = (col_cur < CW'(2)) || (row_cur < RW'(2));

        gx_pos = {3'b000, win_q[0][2]} + {2'b00, win_q[1][2], 1'b0} + {3'b000, win_q[2][2]};
        gx_neg = {3'b000, win_q[0][0]} + {2'b00, win_q[1][0], 1'b0} + {3'b000, win_q[2][0]};
        gy_pos = {3'b000, win_q[2][0]} + {2'b00, win_q[2][1], 1'b0} + {3'b000, win_q[2][2]};
        gy_neg = {3'b000, win_q[0][0]} + {2'b00, win_q[0][1], 1'b0} + {3'b000, win_q[0][2]};

        s2_valid_d  = s1_valid_q;
        s2_data_d   = s1_data_q;
        s2_grey_d   = s1_grey_q;
        s2_mode_d   = s1_mode_q;
        s2_border_d = s1_border_q;
        s2_gx_d     = gx_pos - gx_neg;
        s2_gy_d     = gy_pos - gy_neg;

        abs_x    = s2_gx_q[12] ? 13'(-s2_gx_q) : 13'(s2_gx_q);
        abs_y    = s2_gy_q[12] ? 13'(-s2_gy_q) : 13'(s2_gy_q);
        mag_full = {1'b0, abs_x} + {1'b0, abs_y};

        s3_valid_d = s2_valid_q;
        s3_data_d  = s2_data_q;
        s3_grey_d  = s2_grey_q;
        s3_mode_d  = s2_mode_q;
        if (s2_border_q) begin
            s3_mag_d = '0;
        end else if (mag_full > 14'(PIX_MAX)) begin
            s3_mag_d = PIX_MAX;
        end else begin
            s3_mag_d = mag_full[9:0];
        end

        case (s3_mode_q)
            2'b01:   result = s3_grey_q;
            2'b10:   result = s3_mag_q;
            2'b11:   result = (s3_mag_q >= iTHRESH) ? PIX_MAX : '0;
            default: result = '0;
        endcase

        out_valid_d = s3_valid_q;
        out_data_d  = (s3_mode_q == 2'b00) ? s3_data_q : {result, result, result};

        // The FIFO flag is applied combinationally so the drop matches the write cycle.
        if (out_valid_q && iFIFO_FULL) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge CCD_FIFO_WRCLK) begin
        if (iDVAL) begin
            lb1_mem[col_cur] <= grey;
            lb2_mem[col_cur] <= lb1_rd;
        end
    end

    always_ff @(posedge CCD_FIFO_WRCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            col_q       <= '0;
            row_q       <= '0;
            mode_q      <= '0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_q[i][j] <= '0;
                end
            end
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_grey_q   <= '0;
            s1_mode_q   <= '0;
            s1_border_q <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            s2_grey_q   <= '0;
            s2_mode_q   <= '0;
            s2_border_q <= 1'b0;
            s2_gx_q     <= '0;
            s2_gy_q     <= '0;
            s3_valid_q  <= 1'b0;
            s3_data_q   <= '0;
            s3_grey_q   <= '0;
            s3_mode_q   <= '0;
            s3_mag_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            mode_q      <= mode_d;
            win_q       <= win_d;
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_grey_q   <= s1_grey_d;
            s1_mode_q   <= s1_mode_d;
            s1_border_q <= s1_border_d;
            s2_valid_q  <= s2_valid_d;
            s2_data_q   <= s2_data_d;
            s2_grey_q   <= s2_grey_d;
            s2_mode_q   <= s2_mode_d;
            s2_border_q <= s2_border_d;
            s2_gx_q     <= s2_gx_d;
            s2_gy_q     <= s2_gy_d;
            s3_valid_q  <= s3_valid_d;
            s3_data_q   <= s3_data_d;
            s3_grey_q   <= s3_grey_d;
            s3_mode_q   <= s3_mode_d;
            s3_mag_q    <= s3_mag_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ovf_q       <= ovf_d;
        end
    end

    assign oDATA     = out_data_q;
    assign oDVAL     = out_valid_q & ~iFIFO_FULL;
    assign oOVERFLOW = ovf_q;
    assign oMODE     = mode_q;

endmodule
`default_nettype wire

// File: tb/tb_sobel_edge_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sobel_edge_stage: directed stimulus with a queue scoreboard and monitor.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_sobel_edge_stage;
    localparam int W = 8;
    localparam int H = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [29:0] iDATA = '0;
    logic        iDVAL = 1'b0;
    logic        iFRAME_START = 1'b0;
    logic [1:0]  iMODE = 2'b00;
    logic [9:0]  iTHRESH = 10'd400;
    logic        iFIFO_FULL = 1'b0;
    logic [29:0] oDATA;
    logic        oDVAL;
    logic        oOVERFLOW;
    logic [1:0]  oMODE;

    sobel_edge_stage #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .CCD_FIFO_WRCLK (clk),
        .RESET_N        (rst_n),
        .iDATA          (iDATA),
        .iDVAL          (iDVAL),
        .iFRAME_START   (iFRAME_START),
        .iMODE          (iMODE),
        .iTHRESH        (iTHRESH),
        .iFIFO_FULL     (iFIFO_FULL),
        .oDATA          (oDATA),
        .oDVAL          (oDVAL),
        .oOVERFLOW      (oOVERFLOW),
        .oMODE          (oMODE)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [29:0] data;
    } exp_t;
    exp_t q[$];

    int checks   = 0;
    int failures = 0;
    int full_from = -100;
    int full_to   = -100;

    always @(posedge clk) begin
        #1;
        iFIFO_FULL = (cyc >= full_from) && (cyc <= full_to);
    end

    function automatic logic [29:0] rep(input logic [9:0] v);
        return {v, v, v};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [29:0] d, input logic fs, input logic [1:0] m,
                        input logic [29:0] e);
        @(posedge clk);
        #1;
        iDATA        = d;
        iDVAL        = 1'b1;
        iFRAME_START = fs;
        iMODE        = m;
        if (!((cyc + 4 >= full_from) && (cyc + 4 <= full_to)))
            q.push_back('{due: cyc + 4, data: e});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            iDVAL        = 1'b0;
            iFRAME_START = 1'b0;
        end
    endtask

    // Monitor: every presented result must match the head of the queue in value and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            while (q.size() > 0 && q[0].due < cyc) begin
                e = q.pop_front();
                checks++;
                failures++;
                $display("FAIL missing_result: got none at cycle %0d expected %h", e.due, e.data);
            end
            if (oDVAL) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_result: got %h at cycle %0d expected no output", oDATA, cyc);
                end else begin
                    e = q.pop_front();
                    if (e.due != cyc || oDATA !== e.data) begin
                        failures++;
                        $display("FAIL result: got %h at cycle %0d expected %h at cycle %0d",
                                 oDATA, cyc, e.data, e.due);
                    end
                end
            end
        end
    end

    initial begin
        int c;
        int r;
        logic [9:0] v;
        logic [9:0] ex;

        repeat (3) @(posedge clk);
        #1;
        check("reset_odval", {31'd0, oDVAL}, 32'd0);
        check("reset_odata", {2'd0, oDATA}, 32'd0);
        check("reset_ovf", {31'd0, oOVERFLOW}, 32'd0);
        check("reset_omode", {30'd0, oMODE}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Bypass: a single pixel, nothing else may appear.
        send(30'h3FF00155, 1'b1, 2'b00, 30'h3FF00155);
        idle(8);
        check("bypass_omode", {30'd0, oMODE}, 32'd0);

        // Grey with sparse valid.
        send({10'd300, 10'd600, 10'd903}, 1'b1, 2'b01, rep(10'd601));
        idle(1);
        send({10'd0, 10'd0, 10'd0}, 1'b0, 2'b01, rep(10'd0));
        idle(2);
        send({10'd1023, 10'd1023, 10'd1023}, 1'b0, 2'b01, rep(10'd1023));
        send({10'd1, 10'd1, 10'd0}, 1'b0, 2'b01, rep(10'd0));
        send({10'd1023, 10'd1023, 10'd1022}, 1'b0, 2'b01, rep(10'd1022));
        idle(6);
        check("grey_omode", {30'd0, oMODE}, 32'd1);

        // Sobel step edge, with bubbles, running into the next frame's first row.
        for (int i = 0; i < W * H + 9; i++) begin
            c  = i % W;
            r  = (i / W) % H;
            v  = (c >= 4) ? 10'd1023 : 10'd0;
            ex = (c >= 2 && r >= 2 && (c == 4 || c == 5)) ? 10'd1023 : 10'd0;
            if (i % 5 == 4) idle(1);
            send(rep(v), i == 0, 2'b10, rep(ex));
        end
        idle(6);
        check("sobel_omode", {30'd0, oMODE}, 32'd2);

        // Threshold on a 50-per-column ramp (interior magnitude 400); mid-frame mode change ignored.
        iTHRESH = 10'd400;
        for (int i = 0; i < W * H; i++) begin
            c  = i % W;
            r  = i / W;
            v  = 10'(50 * c);
            ex = (c >= 2 && r >= 2) ? 10'd1023 : 10'd0;
            send(rep(v), i == 0, (i >= 20) ? 2'b01 : 2'b11, rep(ex));
        end
        idle(6);
        check("thresh_omode_hold", {30'd0, oMODE}, 32'd3);
        iTHRESH = 10'd401;
        for (int i = 0; i < W * H; i++) begin
            c = i % W;
            send(rep(10'(50 * c)), i == 0, 2'b11, rep(10'd0));
        end
        idle(6);
        check("pre_overflow_ovf", {31'd0, oOVERFLOW}, 32'd0);

        // Overflow: three results dropped while the FIFO reports full.
        for (int i = 0; i < W * H; i++) begin
            c  = i % W;
            r  = i / W;
            v  = (c >= 4) ? 10'd1023 : 10'd0;
            ex = (c >= 2 && r >= 2 && (c == 4 || c == 5)) ? 10'd1023 : 10'd0;
            if (i == 35) begin
                full_from = cyc + 5;
                full_to   = cyc + 7;
            end
            send(rep(v), i == 0, 2'b10, rep(ex));
        end
        idle(6);
        check("overflow_set", {31'd0, oOVERFLOW}, 32'd1);
        idle(4);
        check("overflow_sticky", {31'd0, oOVERFLOW}, 32'd1);

        // Reset mid-stream: outputs clear at once and pending results never appear.
        for (int i = 0; i < 6; i++) begin
            send({10'd30, 10'd30, 10'd30}, i == 0, 2'b01, rep(10'd30));
        end
        @(posedge clk);
        #1;
        q.delete();
        iDVAL        = 1'b0;
        iFRAME_START = 1'b0;
        rst_n        = 1'b0;
        #1;
        check("midreset_odval", {31'd0, oDVAL}, 32'd0);
        check("midreset_odata", {2'd0, oDATA}, 32'd0);
        check("midreset_ovf", {31'd0, oOVERFLOW}, 32'd0);
        check("midreset_omode", {30'd0, oMODE}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(8);
        check("queue_drained", q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
